// File: rtl/systolic_feed_ctrl.sv
// Streams a captured ARRAY_W x ARRAY_L matrix into a systolic array with a one-cycle skew per row.
// Optional stall input is enabled by defining SYSTOLIC_FEED_CTRL_STALL_EN.
module systolic_feed_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ARRAY_W      = 4,
    parameter int ARRAY_L      = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
`ifdef SYSTOLIC_FEED_CTRL_STALL_EN
    input  logic                                               stall,
`endif
    input  logic                                               start,
    input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]    matrix_in,
    output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]                 row_data,
    output logic [0:ARRAY_W-1]                                 row_valid,
    output logic                                               busy,
    output logic                                               done
);

    localparam int T_LAST = ARRAY_W + ARRAY_L - 2;
    localparam int TW     = (T_LAST > 0) ? $clog2(T_LAST + 1) : 1;
    localparam logic [TW-1:0] T_LAST_V = TW'(T_LAST);
    localparam int DRAIN_LAST_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_LAST_I);

    typedef logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] mat_t;
    typedef logic [0:ARRAY_W-1][DATA_WIDTH-1:0]              rows_t;
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                               r_state, w_state_next;
    logic [TW-1:0]                        r_t, w_t_next;
    logic [7:0]                           r_drain, w_drain_next;
    mat_t                                 r_buf;
    mat_t                                 w_src;
    logic                                 w_start;
    logic                                 w_stall;
    logic [0:ARRAY_W-1][0:ARRAY_L-1]      w_hit;
    rows_t                                w_row_data_next;
    logic [0:ARRAY_W-1]                   w_row_valid_next;
    logic                                 w_busy_next;
    logic                                 w_done_next;
    rows_t                                r_row_data;
    logic [0:ARRAY_W-1]                   r_row_valid;
    logic                                 r_busy;
    logic                                 r_done;

    assign w_start = (r_state == S_IDLE) && start;

`ifdef SYSTOLIC_FEED_CTRL_STALL_EN
    assign w_stall = stall && ((r_state == S_FEED) || (r_state == S_DRAIN));
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_next;
            r_t     <= w_t_next;
            r_drain <= w_drain_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_t_next     = r_t;
        w_drain_next = r_drain;
        if (!w_stall) begin
            case (r_state)
                S_IDLE: begin
                    w_t_next     = '0;
                    w_drain_next = '0;
                    if (start) w_state_next = S_FEED;
                end
                S_FEED: begin
                    w_drain_next = '0;
                    if (r_t == T_LAST_V) begin
                        w_t_next     = '0;
                        w_state_next = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                    end else begin
                        w_t_next = r_t + 1'b1;
                    end
                end
                S_DRAIN: begin
                    w_t_next = '0;
                    if (r_drain == DRAIN_LAST) begin
                        w_drain_next = '0;
                        w_state_next = S_DONE;
                    end else begin
                        w_drain_next = r_drain + 8'd1;
                    end
                end
                default: begin
                    w_t_next     = '0;
                    w_drain_next = '0;
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (w_start) begin
            r_buf <= matrix_in;
        end
    end

    // On the capture edge the buffer is not yet loaded, so cycle 0 is fed straight from matrix_in.
    assign w_src = w_start ? matrix_in : r_buf;

    genvar gi, gj;
    generate
        for (gi = 0; gi < ARRAY_W; gi++) begin : g_row
            for (gj = 0; gj < ARRAY_L; gj++) begin : g_col
                assign w_hit[gi][gj] = (w_state_next == S_FEED) && (w_t_next == TW'(gi + gj));
            end
            assign w_row_valid_next[gi] = |w_hit[gi];
        end
    endgenerate

    always_comb begin
        w_row_data_next = '0;
        for (int i = 0; i < ARRAY_W; i++) begin
            for (int j = 0; j < ARRAY_L; j++) begin
                if (w_hit[i][j]) w_row_data_next[i] = w_src[i][j];
            end
        end
        w_busy_next = (w_state_next == S_FEED) || (w_state_next == S_DRAIN);
        w_done_next = (w_state_next == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_data  <= '0;
            r_row_valid <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (!w_stall) begin
            r_row_data  <= w_row_data_next;
            r_row_valid <= w_row_valid_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    assign row_data  = r_row_data;
    assign row_valid = r_row_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
